// File: rtl/serializador_msj.sv
// ---------------------------------------------------------------------------
// serializador_msj
//   Async-serial transmitter for the 8-bit message byte. A one-cycle `send`
//   while idle latches `data_input` and emits a frame on `tx`:
//   start (0), 8 data bits LSB first, optional even-parity bit, stop (1).
//   Each bit is held for CLKS_PER_BIT clock cycles.
//
//   Ports
//     clk         system clock, rising edge
//     reset       synchronous active-high reset
//     data_input  byte to transmit, sampled only on the accepting edge
//     send        transmit request, honoured only while ready=1
//     tx          serial line, idles high
//     ready       idle and able to accept send
//     busy        frame in progress (inverse of ready)
//     done        one-cycle pulse on the edge the stop bit completes
//
//   State | meaning
//   ------+----------------------------------------------------
//   IDLE  | line high, waiting for send
//   START | start bit (0) on the line
//   DATA  | data bit idx_q on the line, LSB first
//   PARITY| even-parity bit on the line (PARITY_EN=1 only)
//   STOP  | stop bit (1) on the line; exits to IDLE with done
// ---------------------------------------------------------------------------
module serializador_msj #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_input,
  input  logic       send,
  output logic       tx,
  output logic       ready,
  output logic       busy,
  output logic       done
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;

  // Last cycle of the current serial bit; the next bit is loaded on this edge.
  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Bit-period divider free-runs while a frame is active.
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
        if (send) begin
          shift_d = data_input;
          par_d   = ^data_input;
          state_d = S_START;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_START: begin
        if (bit_end) begin
          // The shift register always presents the next data bit at [0].
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            if (PARITY_EN) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serializador_msj.sv
// Bench for serializador_msj: three instances (C=4 no parity, C=4 parity,
// C=1 no parity) checked cycle by cycle against a frame built from the
// async-serial framing rules.
module tb_serializador_msj;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] send_w;
  logic [7:0] data_w [3];
  logic [2:0] tx_w, ready_w, busy_w, done_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serializador_msj #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u_a (
    .clk(clk), .reset(reset), .data_input(data_w[0]), .send(send_w[0]),
    .tx(tx_w[0]), .ready(ready_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  serializador_msj #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_b (
    .clk(clk), .reset(reset), .data_input(data_w[1]), .send(send_w[1]),
    .tx(tx_w[1]), .ready(ready_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  serializador_msj #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0)) u_c (
    .clk(clk), .reset(reset), .data_input(data_w[2]), .send(send_w[2]),
    .tx(tx_w[2]), .ready(ready_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cpb_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic bit par_of(input int k);
    return (k == 1);
  endfunction

  // Starts at a negedge with instance k idle. Ends at the negedge after the
  // edge that completes the frame (done expected high there), unless aborted.
  task automatic run_frame(input int k, input logic [7:0] d, input bit hold,
                           input int chg_at, input logic [7:0] chg_val,
                           input int abort_at);
    bit frm[$];
    bit exp_q[$];
    int c;
    c = cpb_of(k);
    frm.push_back(1'b0);
    for (int i = 0; i < 8; i++) frm.push_back(d[i]);
    if (par_of(k)) frm.push_back(^d);  // makes total count of ones even
    frm.push_back(1'b1);
    foreach (frm[b]) for (int r = 0; r < c; r++) exp_q.push_back(frm[b]);

    data_w[k] = d;
    send_w[k] = 1'b1;
    @(negedge clk);
    if (!hold) send_w[k] = 1'b0;
    for (int j = 0; j < exp_q.size(); j++) begin
      if (j == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_eq($sformatf("abort k%0d", k),
               {tx_w[k], ready_w[k], busy_w[k], done_w[k]}, 4'b1100);
        return;
      end
      chk_eq($sformatf("tx k%0d d%02h j%0d", k, d, j), tx_w[k], exp_q[j]);
      chk_eq($sformatf("stat k%0d j%0d", k, j),
             {ready_w[k], busy_w[k], done_w[k]}, 3'b010);
      if (j == chg_at) data_w[k] = chg_val;
      @(negedge clk);
    end
    chk_eq($sformatf("done k%0d d%02h", k, d),
           {tx_w[k], ready_w[k], busy_w[k], done_w[k]}, 4'b1101);
  endtask

  task automatic idle_chk(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_eq($sformatf("idle k%0d", k),
             {tx_w[k], ready_w[k], busy_w[k], done_w[k]}, 4'b1100);
    end
  endtask

  initial begin
    int k;
    logic [7:0] d;
    reset  = 1'b1;
    send_w = '0;
    for (int i = 0; i < 3; i++) data_w[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk_eq($sformatf("reset k%0d", i),
             {tx_w[i], ready_w[i], busy_w[i], done_w[i]}, 4'b1100);
    reset = 1'b0;
    idle_chk(0, 1);

    // Basic frame, no parity
    run_frame(0, 8'hA5, 1'b0, -1, 8'h00, -1);
    idle_chk(0, 1);

    // Parity frames: odd and even data weight
    run_frame(1, 8'h07, 1'b0, -1, 8'h00, -1);
    idle_chk(1, 1);
    run_frame(1, 8'h03, 1'b0, -1, 8'h00, -1);
    idle_chk(1, 1);

    // send held high: second frame starts the edge after done
    run_frame(0, 8'h3C, 1'b1, 10, 8'hC3, -1);
    run_frame(0, 8'hC3, 1'b0, -1, 8'h00, -1);
    idle_chk(0, 1);

    // data_input changed mid-frame
    run_frame(0, 8'h00, 1'b0, 5, 8'hFF, -1);
    idle_chk(0, 1);

    // reset during data bit 3, then a clean frame
    run_frame(0, 8'h5A, 1'b0, -1, 8'h00, 4 * 4 + 1);
    run_frame(0, 8'h81, 1'b0, -1, 8'h00, -1);
    idle_chk(0, 1);

    // One clock per bit
    run_frame(2, 8'h55, 1'b0, -1, 8'h00, -1);
    idle_chk(2, 1);

    // Randomized frames across all instances
    repeat (24) begin
      k = int'($urandom_range(0, 2));
      d = 8'($urandom);
      run_frame(k, d, 1'b0, int'($urandom_range(0, 30)), 8'($urandom), -1);
      idle_chk(k, int'($urandom_range(1, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
